// File: rtl/elastic_pipe_register.sv
// -----------------------------------------------------------------------------
// elastic_pipe_register
//
// Moves a WIDTH-bit word through DEPTH register stages under a valid/ready
// handshake. Empty stages (bubbles) are refilled while the output is stalled,
// so the pipe only pushes back upstream once every stage holds a word.
// A synchronous flush empties the pipe. A registered occupancy count is
// provided alongside.
//
// Parameters:
//   WIDTH     - data word width in bits (>= 1)
//   DEPTH     - number of register stages (>= 1)
//   RESET_VAL - value loaded into every data stage on reset and on flush
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   flush      in   synchronous clear of all stages
//   in_valid   in   upstream word present
//   in_data    in   upstream word
//   in_ready   out  block accepts in_data this cycle
//   out_valid  out  last stage holds a word
//   out_data   out  last stage word (registered, no path from in_data)
//   out_ready  in   downstream accepts out_data this cycle
//   count      out  number of valid stages, 0..DEPTH
// -----------------------------------------------------------------------------
module elastic_pipe_register #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [DEPTH-1:0] rdy;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Ready chain: a stage can load when it is empty or when everything below it
  // can move. Built from the output side as a running "all full so far" AND,
  // which is the unrolled form of rdy[i] = ~vld_q[i] | rdy[i+1].
  always_comb begin
    logic all_full;
    // NOTE: every variable written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    all_full = 1'b1;
    rdy      = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      all_full = all_full & vld_q[i];
      rdy[i]   = ~all_full | out_ready;
    end
  end

  // Next state. Data only moves when a valid word moves into a stage, so an
  // emptied last stage keeps showing its previous word and in_data is sampled
  // only on an input transfer.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush) begin
      vld_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = RESET_VAL;
      end
    end else begin
      if (rdy[0]) begin
        vld_d[0] = in_valid;
        if (in_valid) begin
          data_d[0] = in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          vld_d[i] = vld_q[i-1];
          if (vld_q[i-1]) begin
            data_d[i] = data_q[i-1];
          end
        end
      end
    end
    count_d = CNT_W'($countones(vld_d));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q   <= '0;
      count_q <= '0;
      // NOTE: the data stages are reset too (not just the valid bits) so that
      // out_data shows RESET_VAL after reset and no X ever reaches downstream.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      // NOTE: state registers use non-blocking assignments so every stage
      // samples the pre-edge value of its neighbour; blocking assignments here
      // would let a word race through several stages in one edge.
      vld_q   <= vld_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_elastic_pipe_register.sv
// -----------------------------------------------------------------------------
// Bench for elastic_pipe_register. Four instances with different WIDTH/DEPTH
// run side by side. Per instance, the driver pushes every accepted word into a
// scoreboard queue; a monitor pops and compares on each output transfer, and a
// per-cycle checker compares count and in_ready against the queue occupancy.
// -----------------------------------------------------------------------------
module tb_elastic_pipe_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : gen_cfg
    localparam int W  = (g == 2) ? 1 : (g == 3) ? 16 : 4;
    localparam int D  = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 1 : 4;
    localparam int CW = $clog2(D + 1);
    localparam logic [W-1:0] RV = (g == 3) ? W'(16'hBEEF) : W'(0);

    logic          reset_n   = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic [W-1:0]  in_data   = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;
    logic [W-1:0]  sb_q [$];
    int            n_out = 0;

    elastic_pipe_register #(
      .WIDTH    (W),
      .DEPTH    (D),
      .RESET_VAL(RV)
    ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_ready(out_ready),
      .count    (count)
    );

    // One clock: drive at posedge+1, record the handshake at negedge, return
    // at posedge+1 of the following edge.
    task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy,
                       input logic fl, output bit acc);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      acc = iv && in_ready && reset_n;
      if (fl) sb_q.delete();
      else if (acc) sb_q.push_back(d);
      @(posedge clk);
      #1;
    endtask

    // Monitor: every output transfer must match the oldest pending word.
    always @(negedge clk) begin
      if (reset_n && !flush && out_valid && out_ready) begin
        n_out++;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL cfg%0d unexpected_out: actual=%0h required=no output", g, out_data);
        end else begin
          check($sformatf("cfg%0d out_data", g), 32'(out_data), 32'(sb_q.pop_front()));
        end
      end
    end

    // Occupancy: count tracks pending words; in_ready is low only when full
    // and stalled.
    always @(posedge clk) begin
      #2;
      if (reset_n) begin
        check($sformatf("cfg%0d count", g), 32'(count), 32'(sb_q.size()));
        check($sformatf("cfg%0d in_ready", g), 32'(in_ready),
              32'((sb_q.size() < D) || out_ready));
      end
    end

    initial begin
      bit acc;
      int n0;
      #11;
      check($sformatf("cfg%0d rst out_valid", g), 32'(out_valid), 32'(0));
      check($sformatf("cfg%0d rst count", g), 32'(count), 32'(0));
      check($sformatf("cfg%0d rst out_data", g), 32'(out_data), 32'(RV));
      check($sformatf("cfg%0d rst in_ready", g), 32'(in_ready), 32'(1));
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;

      if (g == 0) begin
        // Latency: A accepted at edge 1, visible after edge 2, consumed at 3.
        n0 = n_out;
        cyc(1'b1, W'(4'hA), 1'b1, 1'b0, acc);
        check("lat accept", 32'(acc), 32'(1));
        check("lat out_valid e1", 32'(out_valid), 32'(0));
        check("lat count e1", 32'(count), 32'(1));
        cyc(1'b0, '0, 1'b1, 1'b0, acc);
        check("lat out_valid e2", 32'(out_valid), 32'(1));
        check("lat out_data e2", 32'(out_data), 32'(4'hA));
        check("lat count e2", 32'(count), 32'(1));
        cyc(1'b0, '0, 1'b1, 1'b0, acc);
        check("lat count e3", 32'(count), 32'(0));
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, acc);
        check("lat n_out", 32'(n_out - n0), 32'(1));

        // Streaming 1..8: after 8 edges, transfers at edges 3..8 have happened.
        n0 = n_out;
        for (int k = 1; k <= 8; k++) begin
          cyc(1'b1, W'(k), 1'b1, 1'b0, acc);
          check($sformatf("stream accept %0d", k), 32'(acc), 32'(1));
        end
        check("stream n_out fill", 32'(n_out - n0), 32'(6));
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, acc);
        check("stream n_out all", 32'(n_out - n0), 32'(8));

        // Flush collision: two words held, flush with F offered and out_ready=1.
        cyc(1'b1, W'(4'h1), 1'b0, 1'b0, acc);
        cyc(1'b1, W'(4'h2), 1'b0, 1'b0, acc);
        check("flush pre count", 32'(count), 32'(2));
        n0 = n_out;
        cyc(1'b1, W'(4'hF), 1'b1, 1'b1, acc);
        check("flush count", 32'(count), 32'(0));
        check("flush out_valid", 32'(out_valid), 32'(0));
        check("flush out_data", 32'(out_data), 32'(RV));
        repeat (4) cyc(1'b0, '0, 1'b1, 1'b0, acc);
        check("flush n_out", 32'(n_out - n0), 32'(0));

        // Asynchronous reset mid-stream with two words held.
        cyc(1'b1, W'(4'h7), 1'b0, 1'b0, acc);
        cyc(1'b1, W'(4'h8), 1'b0, 1'b0, acc);
        check("mrst pre out_valid", 32'(out_valid), 32'(1));
        #2;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mrst out_valid", 32'(out_valid), 32'(0));
        check("mrst count", 32'(count), 32'(0));
        check("mrst out_data", 32'(out_data), 32'(RV));
        sb_q.delete();
        @(negedge clk);
        #1 reset_n = 1'b1;
        check("mrst release in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        n0 = n_out;
        cyc(1'b1, W'(4'h9), 1'b1, 1'b0, acc);
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, acc);
        check("mrst after n_out", 32'(n_out - n0), 32'(1));
      end

      if (g == 1) begin
        // Backpressure with DEPTH=3: 3,4,5 fill the pipe, 6 is held off.
        n0 = n_out;
        cyc(1'b1, W'(3), 1'b0, 1'b0, acc);
        check("bp accept 3", 32'(acc), 32'(1));
        cyc(1'b1, W'(4), 1'b0, 1'b0, acc);
        check("bp accept 4", 32'(acc), 32'(1));
        check("bp in_ready 2 held", 32'(in_ready), 32'(1));
        cyc(1'b1, W'(5), 1'b0, 1'b0, acc);
        check("bp accept 5", 32'(acc), 32'(1));
        check("bp count full", 32'(count), 32'(3));
        check("bp in_ready full", 32'(in_ready), 32'(0));
        check("bp out_data full", 32'(out_data), 32'(3));
        repeat (2) begin
          cyc(1'b1, W'(6), 1'b0, 1'b0, acc);
          check("bp held off 6", 32'(acc), 32'(0));
        end
        cyc(1'b1, W'(6), 1'b1, 1'b0, acc);
        check("bp accept 6 on emit", 32'(acc), 32'(1));
        check("bp count after swap", 32'(count), 32'(3));
        check("bp out_data after swap", 32'(out_data), 32'(4));
        check("bp n_out swap", 32'(n_out - n0), 32'(1));
        cyc(1'b0, '0, 1'b0, 1'b0, acc);
        check("bp count stalled", 32'(count), 32'(3));
        repeat (4) cyc(1'b0, '0, 1'b1, 1'b0, acc);
        check("bp n_out drain", 32'(n_out - n0), 32'(4));
      end

      // Random handshake on every configuration.
      for (int c = 0; c < 1000; c++) begin
        cyc(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 99) < 60),
            ($urandom_range(0, 99) < 2), acc);
      end
      repeat (D + 2) cyc(1'b0, '0, 1'b1, 1'b0, acc);
      check($sformatf("cfg%0d rand drained", g), 32'(sb_q.size()), 32'(0));
      check($sformatf("cfg%0d rand out_valid", g), 32'(out_valid), 32'(0));
      done_cnt++;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && done_cnt < 4; i++) @(posedge clk);
    if (done_cnt < 4) begin
      total++;
      bad++;
      $display("FAIL timeout: actual done=%0d required=4", done_cnt);
    end
    #20;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
